// File: rtl/ascon_out_collector_pkg.sv
// Shared constants for the Ascon output collector: stream type codes, modes,
// tag geometry and the collector state encoding.
// Pure declarations; no logic, no latency, no flow control.
package ascon_pkg;

  localparam logic [3:0] TYPE_EMPTY  = 4'd0;
  localparam logic [3:0] TYPE_ASSOC  = 4'd1;
  localparam logic [3:0] TYPE_PLAIN  = 4'd2;
  localparam logic [3:0] TYPE_CIPHER = 4'd3;
  localparam logic [3:0] TYPE_TAG    = 4'd4;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_ENC = 1'b1;

  localparam int TAG_WORDS  = 4;
  localparam int TAG_LENGTH = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_DRAIN,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/ascon_out_collector_fifo.sv
// Generic synchronous FIFO with show-ahead read data and occupancy count.
// Latency: pushed word visible on o_pop_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module ascon_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

  // Read/write pointers with one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ascon_out_collector.sv
// Collects the Ascon core output stream, assembles the tag, and releases the
// message (plus tag in ENC) only after authentication; first out_valid two
// cycles after the last tag word. Core side has no backpressure; the output
// holds while out_ready is low. Optional counters: ASCON_COLLECT_STATS_EN.
module ascon_out_collector
  import ascon_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [TAG_LENGTH-1:0]  exp_tag,
  input  logic [31:0]            in_data,
  input  logic [3:0]             in_type,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic [31:0]            out_data,
  output logic [3:0]             out_type,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   auth_ok,
  output logic                   auth_fail,
  output logic                   err,
`ifdef ASCON_COLLECT_STATS_EN
  output logic                   busy,
  output logic [15:0]            msg_count,
  output logic [15:0]            fail_count
`else
  output logic                   busy
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t                r_state, w_state_nxt;
  logic                  r_mode;
  logic [TAG_LENGTH-1:0] r_tag;
  logic [2:0]            r_tag_cnt, w_tag_cnt_nxt;
  logic                  r_bad, r_seen_tag, r_err;
  logic [2:0]            r_tag_idx;
  logic [31:0]           r_out_data;
  logic [3:0]            r_out_type;
  logic                  r_out_valid, r_out_last, r_auth_ok, r_auth_fail;

  logic        w_in_msg, w_in_tag, w_in_word, w_collecting;
  logic        w_push, w_pop, w_load, w_proto_err, w_late_err, w_ok, w_fail, w_clear;
  logic        w_fifo_full, w_fifo_empty, w_have_more, w_slot_free, w_pass;
  logic [31:0] w_fifo_dat, w_tag_word;
  logic [CW-1:0] w_fifo_cnt;

  ascon_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (in_data),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_cnt)
  );

  assign w_in_msg     = in_valid && (in_type == TYPE_PLAIN || in_type == TYPE_CIPHER);
  assign w_in_tag     = in_valid && (in_type == TYPE_TAG);
  assign w_in_word    = w_in_msg || w_in_tag;
  assign w_collecting = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_pass       = !r_bad && ((r_mode == MODE_ENC) || (r_tag == exp_tag));
  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_have_more  = !w_fifo_empty ||
                        ((r_mode == MODE_ENC) && (r_tag_idx < 3'(TAG_WORDS)));

  // Tag count saturates one past the legal maximum so overruns stay visible.
  always_comb begin
    w_tag_cnt_nxt = r_tag_cnt;
    if (w_in_tag && r_tag_cnt != 3'd5) w_tag_cnt_nxt = r_tag_cnt + 3'd1;
  end

  // Select the tag word to emit, most significant word first.
  always_comb begin
    w_tag_word = r_tag[127:96];
    case (r_tag_idx[1:0])
      2'd0:    w_tag_word = r_tag[127:96];
      2'd1:    w_tag_word = r_tag[95:64];
      2'd2:    w_tag_word = r_tag[63:32];
      default: w_tag_word = r_tag[31:0];
    endcase
  end

  // Next-state and per-cycle control; CHECK already loads the first output
  // word so it appears together with the auth pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_proto_err = 1'b0;
    w_late_err  = 1'b0;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        if (w_in_word) begin
          w_state_nxt = ST_COLLECT;
          if (w_in_msg) begin
            if (r_seen_tag || w_fifo_full) w_proto_err = 1'b1;
            else                           w_push      = 1'b1;
          end
          if (w_in_tag && r_tag_cnt >= 3'(TAG_WORDS)) w_proto_err = 1'b1;
          if (in_last) begin
            w_state_nxt = ST_CHECK;
            if (w_tag_cnt_nxt != 3'(TAG_WORDS)) w_proto_err = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        w_late_err = w_in_word;
        if (w_pass) begin
          w_ok        = 1'b1;
          w_state_nxt = ST_DRAIN;
          w_load      = w_have_more;
          w_pop       = w_have_more && !w_fifo_empty;
        end else begin
          w_fail      = 1'b1;
          w_state_nxt = ST_DISCARD;
        end
      end
      ST_DRAIN: begin
        w_late_err = w_in_word;
        if (w_slot_free) begin
          if (w_have_more) begin
            w_load = 1'b1;
            w_pop  = !w_fifo_empty;
          end else begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        w_late_err = w_in_word;
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Message bookkeeping: mode latch, tag shift register, error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= MODE_DEC;
      r_tag       <= '0;
      r_tag_cnt   <= '0;
      r_bad       <= 1'b0;
      r_seen_tag  <= 1'b0;
      r_err       <= 1'b0;
      r_auth_ok   <= 1'b0;
      r_auth_fail <= 1'b0;
    end else begin
      r_auth_ok   <= w_ok;
      r_auth_fail <= w_fail;
      if (w_proto_err || w_late_err) r_err <= 1'b1;
      if (r_state == ST_IDLE && w_in_word) r_mode <= mode;
      if (w_collecting && w_in_tag) r_tag <= {r_tag[95:0], in_data};
      if (w_clear) begin
        r_tag_cnt  <= '0;
        r_bad      <= 1'b0;
        r_seen_tag <= 1'b0;
      end else begin
        if (w_collecting && w_in_tag) begin
          r_tag_cnt  <= w_tag_cnt_nxt;
          r_seen_tag <= 1'b1;
        end
        if (w_proto_err) r_bad <= 1'b1;
      end
    end
  end

  // Output register: loads message words then (ENC) tag words, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_type  <= TYPE_EMPTY;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_tag_idx   <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        if (!w_fifo_empty) begin
          r_out_data <= w_fifo_dat;
          r_out_type <= (r_mode == MODE_ENC) ? TYPE_CIPHER : TYPE_PLAIN;
          r_out_last <= (r_mode == MODE_DEC) && (w_fifo_cnt == CW'(1));
        end else begin
          r_out_data <= w_tag_word;
          r_out_type <= TYPE_TAG;
          r_out_last <= (r_tag_idx == 3'(TAG_WORDS - 1));
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_clear)                      r_tag_idx <= '0;
      else if (w_load && w_fifo_empty)  r_tag_idx <= r_tag_idx + 3'd1;
    end
  end

`ifdef ASCON_COLLECT_STATS_EN
  logic [15:0] r_msg_count, r_fail_count;

  // Saturating counters of authentication outcomes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_count  <= '0;
      r_fail_count <= '0;
    end else begin
      if ((w_ok || w_fail) && r_msg_count != 16'hFFFF) r_msg_count  <= r_msg_count + 16'd1;
      if (w_fail && r_fail_count != 16'hFFFF)          r_fail_count <= r_fail_count + 16'd1;
    end
  end

  assign msg_count  = r_msg_count;
  assign fail_count = r_fail_count;
`endif

  assign out_data  = r_out_data;
  assign out_type  = r_out_type;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign auth_ok   = r_auth_ok;
  assign auth_fail = r_auth_fail;
  assign err       = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule
